// File: rtl/ndwire_scheduler_dataless.sv
// Run/sleep gate for dataless handshake channels.
// LFSR-driven release and grant, capped runner count, starvation bound.
module ndwire_scheduler_dataless #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          MAX_RUNNING  = 2,
  parameter int          MAX_SLEEP    = 7,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CHANNELS-1:0] ins_valid,
  output logic [NUM_CHANNELS-1:0] ins_ready,
  output logic [NUM_CHANNELS-1:0] outs_valid,
  input  logic [NUM_CHANNELS-1:0] outs_ready,
  output logic [NUM_CHANNELS-1:0] running
);

  localparam int N  = NUM_CHANNELS;
  localparam int CW = $clog2(MAX_SLEEP + 1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic SLEEPING = 1'b0;
  localparam logic RUNNING  = 1'b1;

  logic [N-1:0]  run_q, run_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [PW-1:0] rr_q, rr_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic [N-1:0]  fire;
  logic [N-1:0]  rel;
  logic [N-1:0]  grant;

  assign outs_valid = ins_valid & run_q;
  assign ins_ready  = outs_ready & run_q;
  assign running    = run_q;

  always_comb begin
    int remain;
    int free;
    int ng;
    int last;
    int idx;
    logic hit;
    fire   = ins_valid & outs_ready & run_q;
    rel    = fire & lfsr_q[N-1:0];
    remain = 0;
    for (int i = 0; i < N; i++) begin
      remain += int'(run_q[i] & ~rel[i]);
    end
    free  = MAX_RUNNING - remain;
    grant = '0;
    ng    = 0;
    last  = 0;
    idx   = 0;
    hit   = 1'b0;
    // First N slots scan urgent sleepers, next N scan lucky ones.
    if (en) begin
      for (int k = 0; k < 2 * N; k++) begin
        idx = (int'(rr_q) + k) % N;
        if (k < N) begin
          hit = (cnt_q[idx] == CW'(MAX_SLEEP));
        end else begin
          hit = lfsr_q[8 + idx];
        end
        if (hit && run_q[idx] == SLEEPING && !grant[idx] && ng < free) begin
          grant[idx] = 1'b1;
          ng         = ng + 1;
          last       = idx;
        end
      end
    end
    run_d = (run_q & ~rel) | grant;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rel[i] || grant[i]) begin
        cnt_d[i] = '0;
      end else if (run_q[i] == SLEEPING && cnt_q[i] != CW'(MAX_SLEEP)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rr_d   = (ng > 0) ? PW'((last + 1) % N) : rr_q;
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
              lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= {N{SLEEPING}};
      rr_q   <= '0;
      lfsr_q <= LFSR_SEED;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      run_q  <= run_d;
      rr_q   <= rr_d;
      lfsr_q <= lfsr_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ndwire_scheduler_dataless.sv
// Bench for ndwire_scheduler_dataless: two seeds side by side,
// each checked against a queue-based scheduling model.
module tb_ndwire_scheduler_dataless;

  localparam int N    = 4;
  localparam int MAXR = 2;
  localparam int MAXS = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ins_valid;
  logic [3:0] outs_ready;
  logic [3:0] ir_a, ov_a, run_a;
  logic [3:0] ir_b, ov_b, run_b;

  int checks = 0;
  int errors = 0;
  int ndiff  = 0;

  always #10 clk = ~clk;

  ndwire_scheduler_dataless dut (
    .clk(clk), .rst(rst), .en(en),
    .ins_valid(ins_valid), .ins_ready(ir_a),
    .outs_valid(ov_a), .outs_ready(outs_ready),
    .running(run_a)
  );

  ndwire_scheduler_dataless #(.LFSR_SEED(16'h0001)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .ins_valid(ins_valid), .ins_ready(ir_b),
    .outs_valid(ov_b), .outs_ready(outs_ready),
    .running(run_b)
  );

  logic [3:0]  m_run  [2];
  int          m_cnt  [2][4];
  int          m_rr   [2];
  logic [15:0] m_lfsr [2];

  typedef struct {
    logic [3:0] iv;
    logic [3:0] orr;
    logic [3:0] ov;
    logic [3:0] ir;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_run[u] = '0;
      m_rr[u]  = 0;
      for (int i = 0; i < N; i++) m_cnt[u][i] = 0;
    end
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'h0001;
  endtask

  task automatic model_step(input int u, input logic e,
                            input logic [3:0] iv, input logic [3:0] orr);
    logic [3:0] fire, rel, gmask;
    logic       fb;
    int         free;
    int         order[$];
    int         granted[$];
    fire  = iv & orr & m_run[u];
    rel   = fire & m_lfsr[u][3:0];
    free  = MAXR - $countones(m_run[u] & ~rel);
    gmask = '0;
    for (int k = 0; k < N; k++) order.push_back((m_rr[u] + k) % N);
    if (e) begin
      foreach (order[j]) begin
        if (!m_run[u][order[j]] && m_cnt[u][order[j]] == MAXS
            && granted.size() < free) begin
          granted.push_back(order[j]);
          gmask[order[j]] = 1'b1;
        end
      end
      foreach (order[j]) begin
        if (!m_run[u][order[j]] && !gmask[order[j]]
            && m_lfsr[u][8 + order[j]] && granted.size() < free) begin
          granted.push_back(order[j]);
          gmask[order[j]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rel[i] || gmask[i]) m_cnt[u][i] = 0;
      else if (!m_run[u][i])
        m_cnt[u][i] = (m_cnt[u][i] + 1 > MAXS) ? MAXS : m_cnt[u][i] + 1;
    end
    m_run[u] = (m_run[u] & ~rel) | gmask;
    if (granted.size() > 0)
      m_rr[u] = (granted[granted.size() - 1] + 1) % N;
    fb = m_lfsr[u][0] ^ m_lfsr[u][2] ^ m_lfsr[u][3] ^ m_lfsr[u][5];
    m_lfsr[u] = (m_lfsr[u] >> 1) | (16'(fb) << 15);
  endtask

  task automatic step(input logic e, input logic [3:0] iv,
                      input logic [3:0] orr);
    en         = e;
    ins_valid  = iv;
    outs_ready = orr;
    #1;
    chk("run_a", run_a, m_run[0]);
    chk("ov_a", ov_a, iv & m_run[0]);
    chk("ir_a", ir_a, orr & m_run[0]);
    chk("run_b", run_b, m_run[1]);
    chk("ov_b", ov_b, iv & m_run[1]);
    chk("ir_b", ir_b, orr & m_run[1]);
    chk("bound", {3'b0, $countones(run_a) <= MAXR}, 4'b0001);
    if (run_a !== run_b) ndiff++;
    @(posedge clk);
    if (rst) begin
      model_step(0, e, iv, orr);
      model_step(1, e, iv, orr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    en         = 1'b1;
    ins_valid  = '1;
    outs_ready = '1;
    repeat (3) begin
      #1;
      chk("rst_run", run_a, 4'b0000);
      chk("rst_ov", ov_a, 4'b0000);
      chk("rst_ir", ir_a, 4'b0000);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic reset_and_park(input int n);
    do_reset();
    repeat (n) begin
      step(1'b0, 4'($urandom), 4'($urandom));
      chk("park_idle", run_a, 4'b0000);
    end
    step(1'b1, 4'($urandom), 4'($urandom));
    chk("park_grant_a", run_a, 4'b0011);
    chk("park_grant_b", run_b, 4'b0011);
  endtask

  initial begin
    logic       found;
    logic [3:0] fired;
    logic [3:0] r;
    tbl[0] = '{4'b1111, 4'b1111, 4'b0011, 4'b0011};
    tbl[1] = '{4'b0000, 4'b1111, 4'b0000, 4'b0011};
    tbl[2] = '{4'b1010, 4'b0101, 4'b0010, 4'b0001};
    tbl[3] = '{4'b0101, 4'b1010, 4'b0001, 4'b0010};
    tbl[4] = '{4'b1100, 4'b1100, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000};

    rst        = 1'b1;
    en         = 1'b0;
    ins_valid  = '0;
    outs_ready = '0;
    #2;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    found = 1'b0;
    for (int c = 0; c < MAXS + 1; c++) begin
      if (!found) begin
        step(1'b1, 4'b0000, 4'b0000);
        if (run_a != 4'b0000) found = 1'b1;
      end
    end
    chk("first_grant", {3'b0, found}, 4'b0001);

    reset_and_park(50);

    foreach (tbl[i]) begin
      ins_valid  = tbl[i].iv;
      outs_ready = tbl[i].orr;
      #1;
      chk("tbl_ov", ov_a, tbl[i].ov);
      chk("tbl_ir", ir_a, tbl[i].ir);
    end

    repeat (20) begin
      r = 4'($urandom);
      step(r[0], 4'($urandom) | 4'b0010, 4'($urandom) & 4'b1101);
      chk("hold_run", {3'b0, run_a[1]}, 4'b0001);
      chk("hold_ov", {3'b0, ov_a[1]}, 4'b0001);
      chk("hold_ir", {3'b0, ir_a[1]}, 4'b0000);
      chk("hold_run_b", {3'b0, run_b[1]}, 4'b0001);
    end

    reset_and_park(10);
    ins_valid  = 4'b1111;
    outs_ready = 4'b0000;
    #1;
    chk("async_pre_ov", ov_a, 4'b0011);
    #4;
    rst = 1'b0;
    #1;
    chk("async_run", run_a, 4'b0000);
    chk("async_ov", ov_a, 4'b0000);
    chk("async_ir", ir_a, 4'b0000);
    chk("async_run_b", run_b, 4'b0000);
    do_reset();

    fired = '0;
    repeat (1000) begin
      step(1'b1, 4'b1111, 4'b1111);
      fired |= run_a;
    end
    chk("all_fired", fired, 4'b1111);

    repeat (800) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
    end

    chk("seed_diverge", {3'b0, ndiff > 0}, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
